// File: rtl/mac_cfg_seq.sv
// mac_cfg_seq: holds the PHY in reset, then replays a register-write table over the MAC host bus.
// Define MAC_CFG_VERIFY_EN to add a read-back and compare after every write.
module mac_cfg_seq #(
  parameter int NUM_WR = 8,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CLK_FREQ_HZ = 25_800_000,
  parameter int PHY_RST_US = 15000,
  parameter int ACK_TIMEOUT = 1023,
  parameter logic [NUM_WR*AW-1:0] WR_ADDR_TBL = 64'h00_02_0e_0f_0c_0d_0a_0b,
  parameter logic [NUM_WR*DW-1:0] WR_DATA_TBL = 64'h0e_c2_80_00_00_48_de_ac
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          restart,
  input  logic          hready_n,
  input  logic          hdataout_en_n,
  input  logic [DW-1:0] hdataout,
  output logic          hcs_n,
  output logic          hwrite_n,
  output logic          hread_n,
  output logic [AW-1:0] haddr,
  output logic [DW-1:0] hdatain,
  output logic          phy_rst_n,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [3:0]    err_idx
);
  localparam logic [2:0] PHY_RST = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] RD      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;
  localparam longint PHY_RST_CYC = (longint'(CLK_FREQ_HZ) * longint'(PHY_RST_US) + 999_999) / 1_000_000;
  localparam longint CNT_MAX = PHY_RST_CYC > longint'(ACK_TIMEOUT) ? PHY_RST_CYC : longint'(ACK_TIMEOUT);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PHY_END = CW'(PHY_RST_CYC - 1);
  localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LAST = 4'(NUM_WR - 1);
`ifdef MAC_CFG_VERIFY_EN
  localparam logic [2:0] AFTER_WR = RD;
`else
  localparam logic [2:0] AFTER_WR = GAP;
`endif

  logic [2:0] state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr_tbl [16];
  logic [DW-1:0] data_tbl [16];

  // Pad the table to 16 entries so a 4-bit index never selects out of range.
  for (genvar i = 0; i < 16; i++) begin : g_tbl
    if (i < NUM_WR) begin : g_on
      assign addr_tbl[i] = WR_ADDR_TBL[i*AW +: AW];
      assign data_tbl[i] = WR_DATA_TBL[i*DW +: DW];
    end else begin : g_off
      assign addr_tbl[i] = '0;
      assign data_tbl[i] = '0;
    end
  end

  // One shared counter times the PHY reset and the acknowledge timeout.
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    cnt_nxt = cnt + 1'b1;
    case (state)
      PHY_RST: if (cnt == PHY_END) begin
        state_nxt = WR;
        idx_nxt = '0;
        cnt_nxt = '0;
      end
      WR: if (!hready_n) begin
        state_nxt = AFTER_WR;
        cnt_nxt = '0;
      end else if (cnt == ACK_END) state_nxt = ERR;
`ifdef MAC_CFG_VERIFY_EN
      RD: if (!hdataout_en_n) state_nxt = hdataout == data_tbl[idx] ? GAP : ERR;
        else if (cnt == ACK_END) state_nxt = ERR;
`endif
      GAP: begin
        state_nxt = idx == LAST ? DONE : WR;
        idx_nxt = idx == LAST ? idx : idx + 4'd1;
        cnt_nxt = '0;
      end
      DONE, ERR: begin
        cnt_nxt = '0;
        if (restart) begin
          state_nxt = PHY_RST;
          idx_nxt = '0;
        end
      end
      default: state_nxt = PHY_RST;
    endcase
  end

  always_ff @(posedge clk or posedge srst)
    if (srst) begin
      state <= PHY_RST;
      idx <= '0;
      cnt <= '0;
      phy_rst_n <= 1'b0;
      hcs_n <= 1'b1;
      hwrite_n <= 1'b1;
      haddr <= '0;
      hdatain <= '0;
      cfg_busy <= 1'b1;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      err_idx <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      phy_rst_n <= state_nxt != PHY_RST;
      hcs_n <= !(state_nxt == WR || state_nxt == RD);
      hwrite_n <= state_nxt != WR;
      haddr <= state_nxt == WR ? addr_tbl[idx_nxt] : haddr;
      hdatain <= state_nxt == WR ? data_tbl[idx_nxt] : hdatain;
      cfg_busy <= !(state_nxt == DONE || state_nxt == ERR);
      cfg_done <= state_nxt == DONE;
      cfg_err <= state_nxt == ERR;
      err_idx <= state_nxt == ERR ? idx : '0;
    end

`ifdef MAC_CFG_VERIFY_EN
  always_ff @(posedge clk or posedge srst)
    if (srst) hread_n <= 1'b1;
    else hread_n <= state_nxt != RD;
`else
  logic unused;
  assign unused = ^{hdataout_en_n, hdataout};
  assign hread_n = 1'b1;
`endif
endmodule

// File: tb/tb_mac_cfg_seq.sv
// tb_mac_cfg_seq: random-latency host model; observed bus writes are scored against the register table.
module tb_mac_cfg_seq;
  localparam int PHY_CYC = 100;
  localparam int ACK_TO = 10;
`ifdef MAC_CFG_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  logic clk = 1'b0;
  logic srst, restart;
  logic hready_n = 1'b1, hdataout_en_n = 1'b1;
  logic [7:0] hdataout = '0;
  logic hcs_n, hwrite_n, hread_n, phy_rst_n, cfg_busy, cfg_done, cfg_err;
  logic [7:0] haddr, hdatain;
  logic [3:0] err_idx;
  logic [7:0] exp_addr [8] = '{8'h0b, 8'h0a, 8'h0d, 8'h0c, 8'h0f, 8'h0e, 8'h02, 8'h00};
  logic [7:0] exp_data [8] = '{8'hac, 8'hde, 8'h48, 8'h00, 8'h00, 8'h80, 8'hc2, 8'h0e};
  int pa_q[$], pd_q[$], pl_q[$], gap_q[$], lat_q[$], phy_q[$];
  int phy_low = 0, wlen = 0, idle = 0, unstable = 0, strobe_bad = 0, rd_cnt = 0;
  int k = 0, lat = 0, stuck_at = -1;
  bit gap_ok = 1'b0, bad_rd = 1'b0;
  int vec = 0, errs = 0;
  int pb, phb, n;

  mac_cfg_seq #(.CLK_FREQ_HZ(1_000_000), .PHY_RST_US(100), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .srst(srst), .restart(restart), .hready_n(hready_n),
    .hdataout_en_n(hdataout_en_n), .hdataout(hdataout), .hcs_n(hcs_n),
    .hwrite_n(hwrite_n), .hread_n(hread_n), .haddr(haddr), .hdatain(hdatain),
    .phy_rst_n(phy_rst_n), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    rd_model = 8'h00;
    for (int i = 0; i < 8; i++) if (exp_addr[i] == a) rd_model = exp_data[i];
    if (bad_rd && a == 8'h0d) rd_model = 8'h5a;
  endfunction

  // Host responder: acks each write after a random 0..9 wait cycles; noise on handshakes when idle.
  always @(negedge clk) begin
    if (!hwrite_n) begin
      if (k == 0) begin
        lat = (lat_q.size() == stuck_at) ? 1000 : int'($urandom_range(0, 9));
        lat_q.push_back(lat);
      end
      hready_n = k < lat;
      k++;
    end else begin
      k = 0;
      hready_n = 1'($urandom_range(0, 1));
    end
    hdataout_en_n = hread_n ? 1'($urandom_range(0, 1)) : 1'b0;
    hdataout = hread_n ? 8'($urandom) : rd_model(haddr);
  end

  // Bus monitor: PHY reset run lengths, write pulses with address, data, length and preceding idle gap.
  always @(negedge clk) begin
    if (srst) begin
      if (wlen != 0) pl_q.push_back(wlen);
      phy_low = 0;
      wlen = 0;
      gap_ok = 1'b0;
    end else begin
      if (!phy_rst_n) begin
        phy_low++;
        gap_ok = 1'b0;
      end else if (phy_low != 0) begin
        phy_q.push_back(phy_low);
        phy_low = 0;
      end
      if (!hwrite_n) begin
        if (wlen == 0) begin
          pa_q.push_back(int'(haddr));
          pd_q.push_back(int'(hdatain));
          gap_q.push_back(gap_ok ? idle : -1);
        end else if (int'(haddr) != pa_q[$] || int'(hdatain) != pd_q[$]) unstable++;
        wlen++;
      end else if (wlen != 0) begin
        pl_q.push_back(wlen);
        wlen = 0;
        idle = 1;
        gap_ok = 1'b1;
      end else idle++;
      if (hcs_n !== (hwrite_n & hread_n)) strobe_bad++;
      if (!hread_n) rd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_restart();
    sync();
    restart = 1'b1;
    sync();
    restart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (cfg_busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    chk(tag, cfg_busy, 0);
  endtask

  task automatic check_run(input int b, input int pbase, input int cnt, input int stuck);
    chk("phy_len", phy_q.size() > pbase ? phy_q[pbase] : -1, PHY_CYC);
    chk("n_writes", pa_q.size() - b, cnt);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("addr[%0d]", i), pa_q[b+i], exp_addr[i]);
      chk($sformatf("data[%0d]", i), pd_q[b+i], exp_data[i]);
      chk($sformatf("len[%0d]", i), pl_q[b+i], i == stuck ? ACK_TO : lat_q[b+i] + 1);
      chk($sformatf("gap[%0d]", i), gap_q[b+i], i == 0 ? -1 : 1 + VER);
    end
    chk("addr_stable", unstable, 0);
    chk("strobe_consistent", strobe_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b0;
    restart = 1'b0;
    #1 srst = 1'b1;
    repeat (3) sync();
    chk("rst_phy_rst_n", phy_rst_n, 0);
    chk("rst_hcs_n", hcs_n, 1);
    chk("rst_hwrite_n", hwrite_n, 1);
    chk("rst_hread_n", hread_n, 1);
    chk("rst_haddr", haddr, 0);
    chk("rst_hdatain", hdatain, 0);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_err_idx", err_idx, 0);
    srst = 1'b0;
    repeat (40) sync();
    chk("busy_in_phy_rst", cfg_busy, 1);
    pulse_restart();
    wait_idle("run1_idle");
    chk("run1_done", cfg_done, 1);
    chk("run1_err", cfg_err, 0);
    chk("run1_err_idx", err_idx, 0);
    check_run(0, 0, 8, -1);
    chk("run1_reads", rd_cnt, 8 * VER);
    repeat (20) sync();
    chk("done_sticky", cfg_done, 1);
    chk("done_no_writes", pa_q.size(), 8);
    chk("done_hcs_n", hcs_n, 1);
    pb = pa_q.size();
    phb = phy_q.size();
    stuck_at = lat_q.size() + 3;
    pulse_restart();
    chk("restart_clears_done", cfg_done, 0);
    chk("restart_phy_low", phy_rst_n, 0);
    chk("restart_busy", cfg_busy, 1);
    repeat (104) sync();
    chk("busy_in_wr", cfg_busy, 1);
    pulse_restart();
    wait_idle("run2_idle");
    chk("run2_err", cfg_err, 1);
    chk("run2_err_idx", err_idx, 3);
    chk("run2_done", cfg_done, 0);
    check_run(pb, phb, 4, 3);
    repeat (30) sync();
    chk("err_sticky", cfg_err, 1);
    chk("err_no_writes", pa_q.size() - pb, 4);
    chk("err_phy_high", phy_rst_n, 1);
    chk("err_hcs_n", hcs_n, 1);
    stuck_at = -1;
    pb = pa_q.size();
    phb = phy_q.size();
    pulse_restart();
    chk("restart_clears_err", cfg_err, 0);
    chk("restart_clears_idx", err_idx, 0);
    chk("restart_err_phy_low", phy_rst_n, 0);
    wait_idle("run3_idle");
    chk("run3_done", cfg_done, 1);
    check_run(pb, phb, 8, -1);
    pulse_restart();
    n = 0;
    while (!(hwrite_n === 1'b0 && haddr === 8'h0e) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_write5", {hwrite_n, haddr}, {1'b0, 8'h0e});
    #1 srst = 1'b1;
    #1;
    chk("async_hcs_n", hcs_n, 1);
    chk("async_hwrite_n", hwrite_n, 1);
    chk("async_phy_low", phy_rst_n, 0);
    chk("async_haddr", haddr, 0);
    repeat (3) sync();
    srst = 1'b0;
    pb = pa_q.size();
    phb = phy_q.size();
    wait_idle("run4_idle");
    chk("run4_done", cfg_done, 1);
    check_run(pb, phb, 8, -1);
`ifdef MAC_CFG_VERIFY_EN
    bad_rd = 1'b1;
    pb = pa_q.size();
    phb = phy_q.size();
    pulse_restart();
    wait_idle("vfy_bad_idle");
    chk("vfy_bad_err", cfg_err, 1);
    chk("vfy_bad_err_idx", err_idx, 2);
    check_run(pb, phb, 3, -1);
    bad_rd = 1'b0;
    pulse_restart();
    wait_idle("vfy_good_idle");
    chk("vfy_good_done", cfg_done, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
